// File: rtl/joy_snoop_mp_if.sv
// CPU bus view used by the joypad snooper.
//   m2        : CPU M2 phase clock (asynchronous to the fabric clock)
//   cpu_addr  : {!ROMSEL, CPU_ADDR}
//   cpu_data0 : CPU_DATA[0]
//   cpu_rw    : 1 = read, 0 = write
// master drives the bus (CPU / testbench); slave observes it (snooper).
interface joy_snoop_mp_if;
  logic        m2;
  logic [15:0] cpu_addr;
  logic        cpu_data0;
  logic        cpu_rw;

  modport master (output m2, cpu_addr, cpu_data0, cpu_rw);
  modport slave  (input  m2, cpu_addr, cpu_data0, cpu_rw);
endinterface

// File: rtl/joy_snoop_mp.sv
// Passive multi-port joypad snooper. Watches CPU cycles to $4016/$4017 in the
// fabric clock domain and rebuilds the button state of up to NUM_PORTS pads.
// Ports:
//   clk          : fabric clock, at least 16x M2
//   async_nreset : asynchronous active-low reset
//   bus          : CPU bus (slave modport), all signals asynchronous
//   joy          : committed state, port p at [p*BITS +: BITS], 1 = pressed
//   joy_valid    : 1-clk pulse per port when its joy slice is updated
//   hotkey       : 1-clk pulse when the port-0 hotkey fires
// Optional: define JOY_SNOOP_HOTKEY_EN to build the hotkey hold detector;
// otherwise hotkey is tied low.
module joy_snoop_mp #(
  parameter int unsigned     NUM_PORTS   = 2,
  parameter int unsigned     BITS        = 8,
  parameter logic [BITS-1:0] HOTKEY_MASK = BITS'(8'h0C),
  parameter int unsigned     HOLD_FRAMES = 30
) (
  input  logic                      clk,
  input  logic                      async_nreset,
  joy_snoop_mp_if.slave             bus,
  output logic [NUM_PORTS*BITS-1:0] joy,
  output logic [NUM_PORTS-1:0]      joy_valid,
  output logic                      hotkey
);

  localparam int unsigned     CntW   = $clog2(BITS + 1);
  localparam int unsigned     IdxW   = $clog2(BITS);
  localparam logic [CntW-1:0] CntMax = CntW'(BITS);

  // {m2, rw, data0, addr} through a 2-flop synchroniser
  logic [18:0] sync1_q, sync2_q;
  logic [17:0] snap_q;
  logic        m2_d_q;
  logic        m2_s;

  logic                 strobe_q;
  logic [CntW-1:0]      cnt_q   [NUM_PORTS];
  logic [BITS-1:0]      shift_q [NUM_PORTS];
  logic [NUM_PORTS*BITS-1:0] joy_q;
  logic [NUM_PORTS-1:0] joy_valid_q;

  logic                 evt, snap_rw, snap_d, wr_strobe;
  logic [15:0]          snap_addr;
  logic [NUM_PORTS-1:0] port_hit, commit;
  logic [BITS-1:0]      commit_val [NUM_PORTS];

  assign m2_s      = sync2_q[18];
  assign snap_rw   = snap_q[17];
  assign snap_d    = snap_q[16];
  assign snap_addr = snap_q[15:0];

  // One event per M2 fall; the snapshot still holds the last M2-high sample.
  assign evt       = m2_d_q & ~m2_s;
  assign wr_strobe = evt & ~snap_rw & (snap_addr == 16'h4016);

  always_comb begin
    for (int p = 0; p < int'(NUM_PORTS); p++) begin
      port_hit[p]   = evt & snap_rw & ~strobe_q & (snap_addr == 16'h4016 + 16'(p)) &
                      (cnt_q[p] != CntMax);
      commit[p]     = port_hit[p] & (cnt_q[p] == CntMax - 1'b1);
      // Final bit goes to the MSB; lower bits were all written this report.
      commit_val[p] = {snap_d, shift_q[p][BITS-2:0]};
    end
  end

  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      m2_d_q  <= 1'b0;
      snap_q  <= '0;
    end else begin
      sync1_q <= {bus.m2, bus.cpu_rw, bus.cpu_data0, bus.cpu_addr};
      sync2_q <= sync1_q;
      m2_d_q  <= m2_s;
      if (m2_s) snap_q <= sync2_q[17:0];
    end
  end

  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) begin
      strobe_q    <= 1'b0;
      joy_q       <= '0;
      joy_valid_q <= '0;
      for (int p = 0; p < int'(NUM_PORTS); p++) begin
        cnt_q[p]   <= '0;
        shift_q[p] <= '0;
      end
    end else begin
      joy_valid_q <= '0;
      if (wr_strobe) begin
        strobe_q <= snap_d;
        if (snap_d) begin
          for (int p = 0; p < int'(NUM_PORTS); p++) begin
            cnt_q[p]   <= '0;
            shift_q[p] <= '0;
          end
        end
      end else begin
        for (int p = 0; p < int'(NUM_PORTS); p++) begin
          if (port_hit[p]) begin
            shift_q[p][cnt_q[p][IdxW-1:0]] <= snap_d;
            cnt_q[p]                       <= cnt_q[p] + 1'b1;
          end
          if (commit[p]) begin
            joy_q[p*BITS +: BITS] <= commit_val[p];
            joy_valid_q[p]        <= 1'b1;
          end
        end
      end
    end
  end

  assign joy       = joy_q;
  assign joy_valid = joy_valid_q;

`ifdef JOY_SNOOP_HOTKEY_EN
  localparam int unsigned      HoldW   = $clog2(HOLD_FRAMES + 1);
  localparam logic [HoldW-1:0] HoldMax = HoldW'(HOLD_FRAMES);

  logic [HoldW-1:0] hold_q;
  logic             hotkey_q;

  // Saturation at HoldMax keeps the pulse single until a non-matching commit.
  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) begin
      hold_q   <= '0;
      hotkey_q <= 1'b0;
    end else begin
      hotkey_q <= 1'b0;
      if (commit[0]) begin
        if (commit_val[0] == HOTKEY_MASK) begin
          if (hold_q != HoldMax) begin
            hold_q <= hold_q + 1'b1;
            if (hold_q == HoldMax - 1'b1) hotkey_q <= 1'b1;
          end
        end else begin
          hold_q <= '0;
        end
      end
    end
  end

  assign hotkey = hotkey_q;
`else
  logic unused_hotkey_cfg;
  assign unused_hotkey_cfg = ^{HOTKEY_MASK, HOLD_FRAMES};
  assign hotkey = 1'b0;
`endif

endmodule

// File: tb/tb_joy_snoop_mp.sv
module tb_joy_snoop_mp;

  logic        clk = 1'b0;
  logic        async_nreset;
  logic [15:0] joy8;
  logic [1:0]  j8_valid;
  logic        hot8;
  logic [15:0] joy16;
  logic [0:0]  j16_valid;
  logic        hot16;

  int n_total = 0;
  int n_pass  = 0;
  int cyc_cnt = 0;
  int fall_a  = 0;
  int fall_b  = 0;
  int hc      = 0;

  typedef struct packed {
    logic [7:0] v;
    logic       hot;
  } exp0_t;

  exp0_t       q0[$];
  logic [7:0]  q1[$];
  logic [15:0] q16[$];

  joy_snoop_mp_if bus_a ();
  joy_snoop_mp_if bus_b ();

  joy_snoop_mp #(
    .NUM_PORTS  (2),
    .BITS       (8),
    .HOTKEY_MASK(8'h0C),
    .HOLD_FRAMES(3)
  ) dut8 (
    .clk         (clk),
    .async_nreset(async_nreset),
    .bus         (bus_a),
    .joy         (joy8),
    .joy_valid   (j8_valid),
    .hotkey      (hot8)
  );

  joy_snoop_mp #(
    .NUM_PORTS  (1),
    .BITS       (16),
    .HOTKEY_MASK(16'h000C),
    .HOLD_FRAMES(3)
  ) dut16 (
    .clk         (clk),
    .async_nreset(async_nreset),
    .bus         (bus_b),
    .joy         (joy16),
    .joy_valid   (j16_valid),
    .hotkey      (hot16)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  // One M2 period: 8 clk high, 8 clk low; bus held stable across the fall.
  task automatic bus_cycle(input bit sel, input logic [15:0] a, input logic rw, input logic d);
    if (!sel) begin
      bus_a.cpu_addr = a; bus_a.cpu_rw = rw; bus_a.cpu_data0 = d; bus_a.m2 = 1'b1;
    end else begin
      bus_b.cpu_addr = a; bus_b.cpu_rw = rw; bus_b.cpu_data0 = d; bus_b.m2 = 1'b1;
    end
    repeat (8) @(negedge clk);
    if (!sel) begin
      bus_a.m2 = 1'b0; fall_a = cyc_cnt;
    end else begin
      bus_b.m2 = 1'b0; fall_b = cyc_cnt;
    end
    repeat (8) @(negedge clk);
  endtask

  // Expected port-0 commit plus the hotkey bit the hold rule predicts.
  task automatic push0(input logic [7:0] v);
    exp0_t e;
    e.v   = v;
    e.hot = 1'b0;
`ifdef JOY_SNOOP_HOTKEY_EN
    if (v == 8'h0C) begin
      if (hc < 3) begin
        hc++;
        e.hot = (hc == 3);
      end
    end else begin
      hc = 0;
    end
`endif
    q0.push_back(e);
  endtask

  task automatic strobe();
    bus_cycle(0, 16'h4016, 1'b0, 1'b1);
    bus_cycle(0, 16'h4016, 1'b0, 1'b0);
  endtask

  task automatic report(input int p, input logic [7:0] v);
    if (p == 0) push0(v);
    else q1.push_back(v);
    strobe();
    for (int i = 0; i < 8; i++) bus_cycle(0, 16'h4016 + 16'(p), 1'b1, v[i]);
  endtask

  task automatic interleaved(input logic [7:0] v0, input logic [7:0] v1);
    push0(v0);
    q1.push_back(v1);
    strobe();
    for (int i = 0; i < 8; i++) begin
      bus_cycle(0, 16'h4016, 1'b1, v0[i]);
      bus_cycle(0, 16'h4017, 1'b1, v1[i]);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (async_nreset) begin
      if (j8_valid[0]) begin
        if (q0.size() == 0) check("p0_unexpected_commit", 1, 0);
        else begin
          exp0_t e;
          e = q0.pop_front();
          check("p0_value", {24'd0, joy8[7:0]}, {24'd0, e.v});
          check("p0_hotkey", {31'd0, hot8}, {31'd0, e.hot});
          check("p0_latency_le4", {31'd0, (cyc_cnt - fall_a) <= 4}, 1);
        end
      end else if (hot8) begin
        check("hotkey_without_commit", 1, 0);
      end
      if (j8_valid[1]) begin
        if (q1.size() == 0) check("p1_unexpected_commit", 1, 0);
        else begin
          logic [7:0] e1;
          e1 = q1.pop_front();
          check("p1_value", {24'd0, joy8[15:8]}, {24'd0, e1});
          check("p1_latency_le4", {31'd0, (cyc_cnt - fall_a) <= 4}, 1);
        end
      end
      if (j16_valid[0]) begin
        if (q16.size() == 0) check("b16_unexpected_commit", 1, 0);
        else begin
          logic [15:0] e16;
          e16 = q16.pop_front();
          check("b16_value", {16'd0, joy16}, {16'd0, e16});
          check("b16_latency_le4", {31'd0, (cyc_cnt - fall_b) <= 4}, 1);
        end
      end
      if (hot16) check("b16_hotkey_never", 1, 0);
    end
  end

  initial begin
    async_nreset = 1'b0;
    bus_a.m2 = 1'b0; bus_a.cpu_addr = '0; bus_a.cpu_rw = 1'b1; bus_a.cpu_data0 = 1'b0;
    bus_b.m2 = 1'b0; bus_b.cpu_addr = '0; bus_b.cpu_rw = 1'b1; bus_b.cpu_data0 = 1'b0;
    repeat (5) @(negedge clk);
    async_nreset = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_joy8", {16'd0, joy8}, 0);
    check("reset_valid8", {30'd0, j8_valid}, 0);
    check("reset_hot8", {31'd0, hot8}, 0);
    check("reset_joy16", {16'd0, joy16}, 0);

    // Basic report, then stray reads: 4 on $4017 and a 9th on $4016
    report(0, 8'h89);
    for (int i = 0; i < 4; i++) bus_cycle(0, 16'h4017, 1'b1, 1'b1);
    bus_cycle(0, 16'h4016, 1'b1, 1'b0);
    strobe();
    check("p1_no_partial_commit", {24'd0, joy8[15:8]}, 0);
    check("p0_holds_after_9th", {24'd0, joy8[7:0]}, 32'h89);

    // Partial report discarded by a strobe
    for (int i = 0; i < 5; i++) bus_cycle(0, 16'h4016, 1'b1, 1'b1);
    report(0, 8'h00);

    // Strobe held high: reads ignored; $4017 write leaves strobe alone
    bus_cycle(0, 16'h4016, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      bus_cycle(0, 16'h4016, 1'b1, 1'b1);
      bus_cycle(0, 16'h4017, 1'b1, 1'b1);
    end
    bus_cycle(0, 16'h4017, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) bus_cycle(0, 16'h4016, 1'b1, 1'b1);
    check("strobe_high_no_commit", {24'd0, joy8[7:0]}, 0);

    // Write $4017=1 mid-report must neither set strobe nor clear counters
    begin
      logic [7:0] v;
      v = 8'h53;
      push0(v);
      bus_cycle(0, 16'h4016, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) begin
        if (i == 4) bus_cycle(0, 16'h4017, 1'b0, 1'b1);
        bus_cycle(0, 16'h4016, 1'b1, v[i]);
      end
    end

    // Port 1 and interleaved independent ports
    report(1, 8'hA5);
    check("p0_kept_after_p1", {24'd0, joy8[7:0]}, 32'h53);
    interleaved(8'h3C, 8'hC3);

    // Hotkey hold sequence
    for (int k = 0; k < 4; k++) report(0, 8'h0C);
    report(0, 8'h00);
    for (int k = 0; k < 3; k++) report(0, 8'h0C);

    // 16-bit pad: alternating 1,0 from bit 0
    q16.push_back(16'h5555);
    bus_cycle(1, 16'h4016, 1'b0, 1'b1);
    bus_cycle(1, 16'h4016, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      bus_cycle(1, 16'h4016, 1'b1, (i % 2) == 0);
      if (i == 7) check("b16_no_commit_at_8", {16'd0, joy16}, 0);
    end
    repeat (4) @(negedge clk);
    check("b16_final", {16'd0, joy16}, 32'h5555);

    // Asynchronous reset mid-report
    strobe();
    for (int i = 0; i < 4; i++) bus_cycle(0, 16'h4016, 1'b1, 1'b1);
    #2 async_nreset = 1'b0;
    #1;
    check("midreset_joy8", {16'd0, joy8}, 0);
    check("midreset_valid8", {30'd0, j8_valid}, 0);
    check("midreset_hot8", {31'd0, hot8}, 0);
    check("midreset_joy16", {16'd0, joy16}, 0);
    hc = 0;
    repeat (3) @(negedge clk);
    async_nreset = 1'b1;
    repeat (2) @(negedge clk);

    // Reads after reset count without a strobe
    begin
      logic [7:0] v;
      v = 8'h0C;
      push0(v);
      for (int i = 0; i < 8; i++) bus_cycle(0, 16'h4016, 1'b1, v[i]);
    end

    repeat (20) @(negedge clk);
    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);
    check("q16_drained", q16.size(), 0);
    check("final_p0", {24'd0, joy8[7:0]}, 32'h0C);
    check("final_p1", {24'd0, joy8[15:8]}, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
